// File: rtl/exu_alu_enable_seq.sv
// ALU operand-gate sequencer: at most one of adder/shifter is enabled at a time,
// and any change of active unit is separated by CLR_CYCLES all-gates-low cycles.
module exu_alu_enable_seq #(
  parameter int unsigned CLR_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        freeze,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [1:0]  req_class,
  output logic        req_ready,
  output logic        issue,
  output logic        adder_enable,
  output logic        shift_enable,
  output logic        busy,
  output logic [15:0] switch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHF,
    S_CLR
  } state_t;

  localparam logic [3:0] CLR_LOAD = 4'(CLR_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_clr_cnt;
  logic [15:0] r_switch_cnt;
  logic        r_adder_en;
  logic        r_shift_en;
  logic        r_busy;

  state_t      w_next;
  logic [3:0]  w_clr_next;
  logic        w_ready;
  logic        w_accept;
  logic        w_is_add;
  logic        w_is_shf;
  logic        w_enter_clr;

  assign w_is_add = (req_class == 2'b01);
  assign w_is_shf = (req_class == 2'b10);

  // Reset is folded in so nothing is accepted while rst_l is low, yet the
  // first cycle after release can already accept.
  always_comb begin
    w_ready = 1'b0;
    if (rst_l && !freeze && !flush) begin
      unique case (r_state)
        S_IDLE:  w_ready = 1'b1;
        S_ADD:   w_ready = !w_is_shf;
        S_SHF:   w_ready = !w_is_add;
        default: w_ready = 1'b0;
      endcase
    end
  end

  assign w_accept  = req_valid & w_ready;
  assign req_ready = w_ready;
  assign issue     = w_accept;

  always_comb begin
    w_next     = r_state;
    w_clr_next = r_clr_cnt;
    if (flush) begin
      unique case (r_state)
        S_ADD, S_SHF: begin
          w_next     = S_CLR;
          w_clr_next = CLR_LOAD;
        end
        S_CLR: begin
          if (r_clr_cnt == 4'd0) w_next = S_IDLE;
          else                   w_clr_next = r_clr_cnt - 4'd1;
        end
        default: w_next = S_IDLE;
      endcase
    end else if (!freeze) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_add)      w_next = S_ADD;
          else if (w_accept && w_is_shf) w_next = S_SHF;
        end
        S_ADD: begin
          if (!(w_accept && w_is_add)) begin
            w_next     = S_CLR;
            w_clr_next = CLR_LOAD;
          end
        end
        S_SHF: begin
          if (!(w_accept && w_is_shf)) begin
            w_next     = S_CLR;
            w_clr_next = CLR_LOAD;
          end
        end
        default: begin
          if (r_clr_cnt == 4'd0) w_next = S_IDLE;
          else                   w_clr_next = r_clr_cnt - 4'd1;
        end
      endcase
    end
  end

  assign w_enter_clr = (w_next == S_CLR) && (r_state != S_CLR);

  // Gates are registered from the next state so they are pure flop outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state      <= S_IDLE;
      r_clr_cnt    <= 4'd0;
      r_switch_cnt <= 16'd0;
      r_adder_en   <= 1'b0;
      r_shift_en   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_clr_cnt  <= w_clr_next;
      r_adder_en <= (w_next == S_ADD);
      r_shift_en <= (w_next == S_SHF);
      r_busy     <= (w_next != S_IDLE);
      if (w_enter_clr && (r_switch_cnt != 16'hFFFF))
        r_switch_cnt <= r_switch_cnt + 16'd1;
    end
  end

  assign adder_enable = r_adder_en;
  assign shift_enable = r_shift_en;
  assign busy         = r_busy;
  assign switch_cnt   = r_switch_cnt;

endmodule

// File: tb/tb_exu_alu_enable_seq.sv
// Bench for exu_alu_enable_seq: two instances (CLR_CYCLES 1 and 3) share one
// stimulus stream and are compared against a unit/quiet-time reference model.
module tb_exu_alu_enable_seq;

  localparam int CLR_A = 1;
  localparam int CLR_B = 3;

  logic        clk;
  logic        rstL;
  logic        freeze;
  logic        flush;
  logic        reqValid;
  logic [1:0]  reqClass;

  logic        ready1, issue1, addEn1, shfEn1, busy1;
  logic [15:0] cnt1;
  logic        ready3, issue3, addEn3, shfEn3, busy3;
  logic [15:0] cnt3;

  int          checkCount = 0;
  int          passCount  = 0;

  // Reference model: active unit (0 none, 1 adder, 2 shifter) and remaining quiet cycles
  int          mUnit[2];
  int          mQuiet[2];
  logic [15:0] mCnt[2];
  int          lastUnit[2];
  int          quietRun[2];

  exu_alu_enable_seq #(.CLR_CYCLES(CLR_A)) dut1 (
    .clk(clk), .rst_l(rstL), .freeze(freeze), .flush(flush),
    .req_valid(reqValid), .req_class(reqClass), .req_ready(ready1),
    .issue(issue1), .adder_enable(addEn1), .shift_enable(shfEn1),
    .busy(busy1), .switch_cnt(cnt1)
  );

  exu_alu_enable_seq #(.CLR_CYCLES(CLR_B)) dut3 (
    .clk(clk), .rst_l(rstL), .freeze(freeze), .flush(flush),
    .req_valid(reqValid), .req_class(reqClass), .req_ready(ready3),
    .issue(issue3), .adder_enable(addEn3), .shift_enable(shfEn3),
    .busy(busy3), .switch_cnt(cnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int clrOf(input int k);
    return (k == 0) ? CLR_A : CLR_B;
  endfunction

  function automatic int normClass(input logic [1:0] c);
    return (c == 2'b11) ? 0 : int'(c);
  endfunction

  function automatic logic modelReady(input int k);
    int cu;
    cu = normClass(reqClass);
    if (!rstL || freeze || flush || mQuiet[k] > 0) return 1'b0;
    if (mUnit[k] == 0 || cu == 0) return 1'b1;
    return (cu == mUnit[k]);
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mUnit[k]    = 0;
      mQuiet[k]   = 0;
      mCnt[k]     = 16'd0;
      lastUnit[k] = 0;
      quietRun[k] = 0;
    end
  endtask

  task automatic enterQuiet(input int k);
    mUnit[k]  = 0;
    mQuiet[k] = clrOf(k);
    if (mCnt[k] != 16'hFFFF) mCnt[k] = mCnt[k] + 16'd1;
  endtask

  task automatic modelStep(input int k, input logic acc);
    int cu;
    cu = normClass(reqClass);
    if (mQuiet[k] > 0) begin
      if (flush || !freeze) mQuiet[k] = mQuiet[k] - 1;
    end else if (mUnit[k] != 0) begin
      if (flush)                          enterQuiet(k);
      else if (freeze)                    ;
      else if (!(acc && cu == mUnit[k]))  enterQuiet(k);
    end else begin
      if (!flush && !freeze && acc && cu != 0) mUnit[k] = cu;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic checkUnit(input int k, input logic a, input logic s, input logic b,
                           input logic [15:0] cnt);
    string pre;
    int    cur;
    pre = (k == 0) ? "clr1" : "clr3";
    checkOutput({pre, "_adder_en"}, 32'(a), 32'(mUnit[k] == 1 && mQuiet[k] == 0));
    checkOutput({pre, "_shift_en"}, 32'(s), 32'(mUnit[k] == 2 && mQuiet[k] == 0));
    checkOutput({pre, "_busy"}, 32'(b), 32'(mUnit[k] != 0 || mQuiet[k] > 0));
    checkOutput({pre, "_switch_cnt"}, 32'(cnt), 32'(mCnt[k]));
    checkOutput({pre, "_exclusive"}, 32'(a & s), 32'd0);
    cur = a ? 1 : (s ? 2 : 0);
    if (cur == 0) quietRun[k]++;
    else begin
      if (lastUnit[k] != 0 && cur != lastUnit[k])
        checkOutput({pre, "_gap"}, 32'(quietRun[k] >= clrOf(k)), 32'd1);
      lastUnit[k] = cur;
      quietRun[k] = 0;
    end
  endtask

  // One clock cycle: drive now, check handshake before the edge, registers after it.
  task automatic doCycle(input logic v, input logic [1:0] c, input logic fz, input logic fl);
    logic [1:0] rdy;
    logic [1:0] acc;
    reqValid = v;
    reqClass = c;
    freeze   = fz;
    flush    = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy[k] = modelReady(k);
      acc[k] = v & rdy[k];
    end
    checkOutput("clr1_req_ready", 32'(ready1), 32'(rdy[0]));
    checkOutput("clr1_issue", 32'(issue1), 32'(acc[0]));
    checkOutput("clr3_req_ready", 32'(ready3), 32'(rdy[1]));
    checkOutput("clr3_issue", 32'(issue3), 32'(acc[1]));
    @(posedge clk);
    for (int k = 0; k < 2; k++) modelStep(k, acc[k]);
    #1;
    checkUnit(0, addEn1, shfEn1, busy1, cnt1);
    checkUnit(1, addEn3, shfEn3, busy3, cnt3);
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] c, input logic fz, input logic fl);
    @(negedge clk);
    doCycle(v, c, fz, fl);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready1"}, 32'(ready1), 32'd0);
    checkOutput({tag, "_issue1"}, 32'(issue1), 32'd0);
    checkOutput({tag, "_adder1"}, 32'(addEn1), 32'd0);
    checkOutput({tag, "_shift1"}, 32'(shfEn1), 32'd0);
    checkOutput({tag, "_busy1"}, 32'(busy1), 32'd0);
    checkOutput({tag, "_cnt1"}, 32'(cnt1), 32'd0);
    checkOutput({tag, "_ready3"}, 32'(ready3), 32'd0);
    checkOutput({tag, "_issue3"}, 32'(issue3), 32'd0);
    checkOutput({tag, "_adder3"}, 32'(addEn3), 32'd0);
    checkOutput({tag, "_shift3"}, 32'(shfEn3), 32'd0);
    checkOutput({tag, "_busy3"}, 32'(busy3), 32'd0);
    checkOutput({tag, "_cnt3"}, 32'(cnt3), 32'd0);
  endtask

  initial begin
    int          holdClass;
    logic [1:0]  rc;

    rstL     = 1'b0;
    reqValid = 1'b1;
    reqClass = 2'b01;
    freeze   = 1'b0;
    flush    = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetState("por");

    @(negedge clk);
    rstL = 1'b1;
    doCycle(1'b0, 2'b00, 1'b0, 1'b0);

    // Back-to-back adder accepts, then drain
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    idle(6);
    checkOutput("pair_switch_cnt1", 32'(cnt1), 32'd1);

    // Shift waiting behind an adder op
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    idle(6);

    // Flush while an adder request is presented
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b1);
    idle(5);

    // Freeze parked in the first quiet cycle
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b1, 2'b10, 1'b1, 1'b0);
    idle(5);

    // Freeze while shifting, then flush overriding freeze during quiet time
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 2'b10, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 2'b00, 1'b1, 1'b1);
    idle(5);

    // Class none / reserved
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    idle(5);

    // Asynchronous reset in the middle of a shift run
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    @(negedge clk);
    reqValid = 1'b0;
    rstL     = 1'b0;
    #1;
    modelReset();
    checkResetState("midrst");
    @(negedge clk);
    rstL = 1'b1;
    doCycle(1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    idle(5);

    // Saturation of the switch counter, preloaded near the top
    @(negedge clk);
    force dut1.r_switch_cnt = 16'hFFFD;
    #1;
    release dut1.r_switch_cnt;
    mCnt[0] = 16'hFFFD;
    doCycle(1'b0, 2'b00, 1'b0, 1'b0);
    repeat (4) begin
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
      idle(4);
    end
    checkOutput("sat_switch_cnt1", 32'(cnt1), 32'h0000FFFF);

    // Random class stream with occasional freeze/flush
    holdClass = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 30) holdClass = $urandom_range(0, 3);
      rc = 2'(holdClass);
      applyStimulus(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, rc,
                    ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
